// File: rtl/pow2_boxcar_lpf_if.sv
// pow2_boxcar_lpf_if: sample-stream bundle for the power-of-two boxcar LPF.
// Carries the input handshake, output handshake and the length/flush controls.
// The master drives samples and controls; the slave is the filter.
interface pow2_boxcar_lpf_if #(
    parameter int BIT_WIDTH = 24,
    parameter int CH_W      = 1,
    parameter int SEL_W     = 3
);
    logic [SEL_W-1:0]            filt_sel;
    logic                        flush;
    logic                        in_valid;
    logic                        in_ready;
    logic [CH_W-1:0]             in_ch;
    logic signed [BIT_WIDTH-1:0] d;
    logic                        out_valid;
    logic                        out_ready;
    logic [CH_W-1:0]             out_ch;
    logic signed [BIT_WIDTH-1:0] q;
    logic                        busy;

    modport master (
        output filt_sel, flush, in_valid, in_ch, d, out_ready,
        input  in_ready, out_valid, out_ch, q, busy
    );

    modport slave (
        input  filt_sel, flush, in_valid, in_ch, d, out_ready,
        output in_ready, out_valid, out_ch, q, busy
    );
endinterface

// File: rtl/pow2_boxcar_lpf.sv
// pow2_boxcar_lpf: multi-channel, time-multiplexed running-average low-pass
// filter of length 2^sel (1 .. 2^MAX_LOG2 taps). Each channel keeps a circular
// delay line, a write pointer and a running sum; a length change or flush
// request drains the output and then clears every delay entry, one per cycle.
// Optional macro LPF_ROUND_EN: round half up before the shift and saturate the
// result to the signed BIT_WIDTH range (default build: plain floor shift).
module pow2_boxcar_lpf #(
    parameter int BIT_WIDTH = 24,
    parameter int MAX_LOG2  = 4,
    parameter int CHANNELS  = 2,
    parameter int SEL_W     = 3,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    pow2_boxcar_lpf_if.slave bus
);
    localparam int DEPTH = 1 << MAX_LOG2;
    localparam int SUM_W = BIT_WIDTH + MAX_LOG2;
    localparam int CNT_W = CH_W + MAX_LOG2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHANNELS * DEPTH - 1);
    localparam logic [CH_W:0]    CH_LIM   = (CH_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0] SEL_MAX  = SEL_W'(MAX_LOG2);
`ifdef LPF_ROUND_EN
    localparam logic signed [SUM_W:0] SAT_MAX = (SUM_W + 1)'((1 << (BIT_WIDTH - 1)) - 1);
    localparam logic signed [SUM_W:0] SAT_MIN = (SUM_W + 1)'(-(1 << (BIT_WIDTH - 1)));
`endif

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic [SEL_W-1:0]            active_sel_q, active_sel_d;
    logic                        flush_pending_q, flush_pending_d;
    logic [CNT_W-1:0]            flush_cnt_q, flush_cnt_d;
    logic signed [SUM_W-1:0]     sum_q [CHANNELS];
    logic signed [SUM_W-1:0]     sum_d [CHANNELS];
    logic [MAX_LOG2-1:0]         wp_q  [CHANNELS];
    logic [MAX_LOG2-1:0]         wp_d  [CHANNELS];
    logic signed [BIT_WIDTH-1:0] mem_q [CHANNELS][DEPTH];
    logic                        out_valid_q, out_valid_d;
    logic [CH_W-1:0]             out_ch_q, out_ch_d;
    logic signed [BIT_WIDTH-1:0] q_q, q_d;

    logic [SEL_W-1:0]            sel_clamped_s;
    logic                        ch_ok_s;
    logic [CH_W-1:0]             ch_s;
    logic [MAX_LOG2-1:0]         l_mod_s;
    logic [MAX_LOG2-1:0]         rd_idx_s;
    logic signed [BIT_WIDTH-1:0] old_s;
    logic signed [SUM_W-1:0]     new_sum_s;
    logic signed [BIT_WIDTH-1:0] q_calc_s;
    logic                        in_ready_s;
    logic                        accept_s;
    logic                        load_s;
    logic                        sel_req_s;
    logic                        mem_we_s;
    logic [CH_W-1:0]             mem_wch_s;
    logic [MAX_LOG2-1:0]         mem_widx_s;
    logic signed [BIT_WIDTH-1:0] mem_wdata_s;
`ifdef LPF_ROUND_EN
    logic [SUM_W:0]              rnd_add_s;
    logic signed [SUM_W:0]       rnd_sum_s;
    logic signed [SUM_W:0]       rnd_shift_s;
`endif

    // Decode the incoming sample: channel check, delay tap, new running sum and scaled result.
    always_comb begin
        if (bus.filt_sel > SEL_MAX) begin
            sel_clamped_s = SEL_MAX;
        end else begin
            sel_clamped_s = bus.filt_sel;
        end
        ch_ok_s = ({1'b0, bus.in_ch} < CH_LIM);
        if (ch_ok_s) begin
            ch_s = bus.in_ch;
        end else begin
            ch_s = '0;
        end
        // L modulo depth: full length wraps to 0, i.e. the entry being overwritten.
        l_mod_s   = MAX_LOG2'(1) << active_sel_q;
        rd_idx_s  = wp_q[ch_s] - l_mod_s;
        old_s     = mem_q[ch_s][rd_idx_s];
        new_sum_s = sum_q[ch_s]
                  + {{MAX_LOG2{bus.d[BIT_WIDTH-1]}}, bus.d}
                  - {{MAX_LOG2{old_s[BIT_WIDTH-1]}}, old_s};
`ifdef LPF_ROUND_EN
        if (active_sel_q != '0) begin
            rnd_add_s = (SUM_W + 1)'(1) << (active_sel_q - SEL_W'(1));
        end else begin
            rnd_add_s = '0;
        end
        rnd_sum_s   = {new_sum_s[SUM_W-1], new_sum_s} + rnd_add_s;
        rnd_shift_s = rnd_sum_s >>> active_sel_q;
        if (rnd_shift_s > SAT_MAX) begin
            q_calc_s = {1'b0, {(BIT_WIDTH - 1){1'b1}}};
        end else if (rnd_shift_s < SAT_MIN) begin
            q_calc_s = {1'b1, {(BIT_WIDTH - 1){1'b0}}};
        end else begin
            q_calc_s = BIT_WIDTH'(rnd_shift_s);
        end
`else
        q_calc_s = BIT_WIDTH'(new_sum_s >>> active_sel_q);
`endif
        in_ready_s = !reset && (state_q == ST_RUN) && (!out_valid_q || bus.out_ready)
                   && !flush_pending_q;
        accept_s   = bus.in_valid && in_ready_s;
        load_s     = accept_s && ch_ok_s;
        sel_req_s  = bus.flush || (sel_clamped_s != active_sel_q);
    end

    // Next-state logic: RUN/FLUSH sequencing, per-channel state and delay-line writes.
    always_comb begin
        state_d         = state_q;
        active_sel_d    = active_sel_q;
        flush_pending_d = flush_pending_q;
        flush_cnt_d     = flush_cnt_q;
        sum_d           = sum_q;
        wp_d            = wp_q;
        mem_we_s        = 1'b0;
        mem_wch_s       = ch_s;
        mem_widx_s      = wp_q[ch_s];
        mem_wdata_s     = bus.d;
        case (state_q)
            ST_RUN: begin
                // No accept is possible while a flush is pending, so draining the output suffices.
                if (flush_pending_q && !out_valid_q) begin
                    state_d         = ST_FLUSH;
                    active_sel_d    = sel_clamped_s;
                    flush_pending_d = bus.flush;
                    flush_cnt_d     = '0;
                    for (int i = 0; i < CHANNELS; i++) begin
                        sum_d[i] = '0;
                        wp_d[i]  = '0;
                    end
                end else begin
                    flush_pending_d = flush_pending_q || sel_req_s;
                    if (load_s) begin
                        sum_d[ch_s] = new_sum_s;
                        wp_d[ch_s]  = wp_q[ch_s] + MAX_LOG2'(1);
                        mem_we_s    = 1'b1;
                    end else begin
                        mem_we_s    = 1'b0;
                    end
                end
            end
            ST_FLUSH: begin
                flush_pending_d = flush_pending_q || sel_req_s;
                mem_we_s        = 1'b1;
                mem_wch_s       = flush_cnt_q[CNT_W-1:MAX_LOG2];
                mem_widx_s      = flush_cnt_q[MAX_LOG2-1:0];
                mem_wdata_s     = '0;
                if (flush_cnt_q == CNT_LAST) begin
                    state_d     = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Output register: load on a kept sample, hold under back-pressure, clear on handoff.
    always_comb begin
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        q_d         = q_q;
        if (load_s) begin
            out_valid_d = 1'b1;
            out_ch_d    = ch_s;
            q_d         = q_calc_s;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Control and output flops; reset aborts any flush in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_RUN;
            active_sel_q    <= '0;
            flush_pending_q <= 1'b0;
            flush_cnt_q     <= '0;
            out_valid_q     <= 1'b0;
            out_ch_q        <= '0;
            q_q             <= '0;
        end else begin
            state_q         <= state_d;
            active_sel_q    <= active_sel_d;
            flush_pending_q <= flush_pending_d;
            flush_cnt_q     <= flush_cnt_d;
            out_valid_q     <= out_valid_d;
            out_ch_q        <= out_ch_d;
            q_q             <= q_d;
        end
    end

    // Per-channel running sums and write pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                sum_q[i] <= '0;
                wp_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                sum_q[i] <= sum_d[i];
                wp_q[i]  <= wp_d[i];
            end
        end
    end

    // Delay-line storage: single write port shared by sample writes and flush clears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int k = 0; k < DEPTH; k++) begin
                    mem_q[c][k] <= '0;
                end
            end
        end else if (mem_we_s) begin
            mem_q[mem_wch_s][mem_widx_s] <= mem_wdata_s;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.q         = q_q;
    assign bus.busy      = (state_q == ST_FLUSH);
endmodule

// File: tb/tb_pow2_boxcar_lpf.sv
// tb_pow2_boxcar_lpf: directed scoreboard bench for pow2_boxcar_lpf.
// The driver pushes hand-computed results into a queue as each sample is
// offered; an independent monitor pops and compares on every output handoff.
module tb_pow2_boxcar_lpf;
    localparam int BW  = 24;
    localparam int ML  = 4;
    localparam int CHN = 2;
    localparam int SW  = 3;
    localparam int CW  = 1;

    typedef struct {
        logic [CW-1:0]        ch;
        logic signed [BW-1:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    pow2_boxcar_lpf_if #(.BIT_WIDTH(BW), .CH_W(CW), .SEL_W(SW)) bus_if ();

    pow2_boxcar_lpf #(
        .BIT_WIDTH(BW), .MAX_LOG2(ML), .CHANNELS(CHN), .SEL_W(SW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every output handoff must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && bus_if.out_valid && bus_if.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got q=%0d ch=%0d, expected none at %0t",
                         bus_if.q, bus_if.out_ch, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("q", bus_if.q, mon_e.val);
                check("out_ch", bus_if.out_ch, mon_e.ch);
            end
        end
    end

    // Offer one sample (called at posedge+1); push its expectation when it is taken.
    task automatic send(input logic [CW-1:0] ch, input int val, input int exp_val);
        int waited;
        exp_t e;
        bus_if.in_valid = 1'b1;
        bus_if.in_ch    = ch;
        bus_if.d        = val[BW-1:0];
        waited = 0;
        @(negedge clk);
        while (!bus_if.in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!bus_if.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no in_ready, expected accept of %0d", val);
        end else begin
            e.ch  = ch;
            e.val = exp_val[BW-1:0];
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
    endtask

    // Wait for a flush to start, count its busy cycles and confirm input is blocked.
    task automatic expect_flush(input string name);
        int w;
        int n;
        w = 0;
        n = 0;
        @(negedge clk);
        while (!bus_if.busy && w < 20) begin
            w++;
            @(negedge clk);
        end
        while (bus_if.busy && n < 100) begin
            n++;
            if (n == 2) check({name, "_in_ready"}, bus_if.in_ready, 0);
            @(negedge clk);
        end
        check({name, "_busy_cycles"}, n, 32);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        reset            = 1'b1;
        bus_if.filt_sel  = '0;
        bus_if.flush     = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_ch     = '0;
        bus_if.d         = '0;
        bus_if.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", bus_if.in_ready, 0);
        check("rst_out_valid", bus_if.out_valid, 0);
        check("rst_busy", bus_if.busy, 0);
        check("rst_q", bus_if.q, 0);
        check("rst_out_ch", bus_if.out_ch, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // L = 1: output equals input.
        send(0, 100, 100);
        send(0, -7, -7);
        send(0, 5, 5);

        // L = 4 warm-up ramp on a constant.
        bus_if.filt_sel = 3'd2;
        expect_flush("flush_l4");
        send(0, 1000, 250);
        send(0, 1000, 500);
        send(0, 1000, 750);
        send(0, 1000, 1000);
        send(0, 1000, 1000);
        send(0, 1000, 1000);

        // L = 2 interleaved channels, no leakage; negative floor.
        bus_if.filt_sel = 3'd1;
        expect_flush("flush_l2");
        send(0, 400, 200);
        send(1, -400, -200);
        send(0, 400, 400);
        send(1, -400, -400);
`ifdef LPF_ROUND_EN
        send(1, -1, -200);
`else
        send(1, -1, -201);
`endif
        send(0, 16, 208);

        // Length change 1 -> 4 mid-stream, then L = 16 ramp.
        bus_if.filt_sel = 3'd4;
        expect_flush("flush_l16");
        for (int k = 1; k <= 16; k++) send(0, 16, k);
        send(1, -16, -1);

        // Out-of-range selection clamps to the active length: no flush.
        bus_if.filt_sel = 3'd7;
        repeat (3) @(negedge clk);
        check("clamp_busy", bus_if.busy, 0);
        check("clamp_in_ready", bus_if.in_ready, 1);
        @(posedge clk);
        #1;

        // Back-pressure: output held, input blocked, then same-cycle reload.
        bus_if.out_ready = 1'b0;
        send(0, 16, 16);
        bus_if.in_valid = 1'b1;
        bus_if.in_ch    = '0;
        bus_if.d        = 24'sd32;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check("stall_in_ready", bus_if.in_ready, 0);
            check("stall_out_valid", bus_if.out_valid, 1);
            check("stall_q", bus_if.q, 16);
        end
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b1;
        send(0, 32, 17);
        @(negedge clk);
        check("no_bubble_out_valid", bus_if.out_valid, 1);
        @(posedge clk);
        #1;

        // L = 2 rounding case.
        bus_if.filt_sel = 3'd1;
        expect_flush("flush_round");
`ifdef LPF_ROUND_EN
        send(1, 3, 2);
        send(1, 0, 2);
`else
        send(1, 3, 1);
        send(1, 0, 1);
`endif

        // Flush and selection change together trigger a single flush.
        bus_if.filt_sel = 3'd0;
        bus_if.flush    = 1'b1;
        @(posedge clk);
        #1;
        bus_if.flush = 1'b0;
        expect_flush("flush_combined");
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("single_flush_busy", bus_if.busy, 0);
        end
        @(posedge clk);
        #1;

        // L = 1 extremes: no wrap.
        send(0, 8388607, 8388607);
        send(0, -8388608, -8388608);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pow2_boxcar_lpf.md
Name: pow2_boxcar_lpf

Overview:
- Multi-channel, time-multiplexed running-average low-pass filter with selectable power-of-two length 2^sel (1..2^MAX_LOG2 taps).
- Successor to the fixed 8-mode LPF bank: generalised in width, depth and channel count, with valid/ready handshakes, a running-sum datapath and a controlled flush whenever the length changes.
- Sits between the audio sample source and the output stage.

Parameters:
- BIT_WIDTH, 24, sample width (two's complement).
- MAX_LOG2, 4, log2 of the maximum averaging length (delay depth per channel = 2^MAX_LOG2).
- CHANNELS, 2, number of interleaved channels; CH_W = max(1, clog2(CHANNELS)).
- SEL_W, 3, width of filt_sel.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- filt_sel  in  SEL_W  requested log2 length; values > MAX_LOG2 clamp to MAX_LOG2.
- flush  in  1  single-cycle request to clear all history.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts input this cycle.
- in_ch  in  CH_W  channel of the input sample; values >= CHANNELS are accepted and dropped.
- d  in  BIT_WIDTH  signed input sample.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream accepts output.
- out_ch  out  CH_W  channel of the output sample.
- q  out  BIT_WIDTH  signed filtered sample.
- busy  out  1  flush in progress.

Behaviour:
- Reset: all outputs 0; active_sel = 0; delay memory, running sums and write pointers cleared; state RUN. Reset asserted mid-flush aborts the flush immediately.
- Per-channel state:
  - circular delay line of 2^MAX_LOG2 entries;
  - write pointer wp[ch] of MAX_LOG2 bits, wraps modulo depth;
  - running sum S[ch], signed, BIT_WIDTH+MAX_LOG2 bits, which cannot overflow.
- Accept = in_valid && in_ready.
  - in_ready = (state == RUN) && (!out_valid || out_ready) && !flush_pending.
- On accept on channel c with L = 2^active_sel:
  - old = mem[c][wp-L] (index modulo depth); for L = 2^MAX_LOG2 this is the entry being overwritten; for L = 1, old = mem[c][wp-1].
  - S[c] <= S[c] + d - old; mem[c][wp] <= d; wp <= wp + 1.
  - q <= (S[c] + d - old) >>> active_sel, arithmetic shift (floor); out_ch <= c; out_valid <= 1.
  - Latency is exactly 1 cycle from accept to out_valid.
- Output holds q and out_ch stable while out_valid && !out_ready. out_valid clears on out_ready unless a new accept occurs in the same cycle, in which case it is reloaded with no bubble. Full throughput is one sample per cycle.
- Selection change: filt_sel (clamped) != active_sel, or flush = 1, sets flush_pending. Both in the same cycle set it once.
- FSM:
  - RUN -> FLUSH when flush_pending, out_valid = 0, and no accept this cycle. On entry, active_sel <= clamped filt_sel.
  - FLUSH: clears one memory entry per cycle across all channels (CHANNELS*2^MAX_LOG2 cycles). S and wp are cleared on entry. busy = 1, in_ready = 0.
  - FLUSH -> RUN after the last entry. flush_pending clears on entry to FLUSH.
  - A filt_sel change during FLUSH re-arms flush_pending, so a second flush follows.
- Warm-up after a flush: output ramps as zeros are averaged out, e.g. constant input X gives X*k/L on the k-th sample, for k <= L.
- Dropped channel (in_ch >= CHANNELS): the sample is consumed and produces no output and no state change.

Optional Feature:
- Macro LPF_ROUND_EN.
- Defined: before the shift, add 2^(active_sel-1) when active_sel > 0 (round half up), computed in BIT_WIDTH+MAX_LOG2+1 bits; the result saturates to the signed BIT_WIDTH range.
- Undefined: pure floor via arithmetic shift; no rounding adder and no saturation logic.

Test Plan:
- Reset, sel = 0, ch0 samples 100, -7, 5 -> q = 100, -7, 5 each 1 cycle after accept; out_ch = 0.
- sel = 2 (L = 4), flush done, ch0 constant 1000 x6 -> q = 250, 500, 750, 1000, 1000, 1000.
- Interleaved ch0 = 400 / ch1 = -400 at L = 2 -> ch0 gives 200, 400; ch1 gives -200, -400; no cross-channel leakage.
- Change filt_sel 1 -> 4 mid-stream -> busy high for 2*16 = 32 cycles, in_ready = 0; with L = 16, first q for input 16 = 1; with 16 samples of 16, q = 16.
- Hold out_ready = 0 for 5 cycles with out_valid = 1 -> q stable, in_ready = 0; release -> next accept in the same cycle, no loss.
- LPF_ROUND_EN, sel = 1, inputs 3, 0 -> q = 2 (floor build: 1); input max positive at L = 1 -> no wrap.
